// File: rtl/spmv_csr_sched.sv
// CSR sparse matrix-vector scheduler: walks row pointers, streams nonzeros into an fp16 multiplier with row tags.
// Optional SPMV_SCHED_PERF_EN adds busy-cycle and nonzero-beat performance counters.
module spmv_csr_sched #(
  parameter int ROW_AW  = 4,
  parameter int NNZ_AW  = 8,
  parameter int COL_AW  = 6,
  parameter int MUL_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ROW_AW:0]   i_num_rows,
  output logic [ROW_AW:0]   o_rp_addr,
  input  logic [NNZ_AW:0]   i_rp_data,
  output logic [NNZ_AW-1:0] o_nz_addr,
  output logic              o_nz_rd,
  input  logic [15:0]       i_nz_val,
  input  logic [COL_AW-1:0] i_nz_col,
  output logic [COL_AW-1:0] o_vec_addr,
  input  logic [15:0]       i_vec,
  output logic              o_mul_vld,
  output logic [15:0]       o_mul_a,
  output logic [15:0]       o_mul_b,
  output logic              o_acc_vld,
  output logic              o_acc_last,
  output logic [ROW_AW-1:0] o_acc_row,
  output logic              o_busy,
  output logic              o_done
`ifdef SPMV_SCHED_PERF_EN
  ,
  output logic [31:0]       o_perf_cycles,
  output logic [NNZ_AW:0]   o_perf_nnz
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_LD_PTR, S_WT_PTR, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [NNZ_AW:0] PTR_ONE = 1;
  localparam logic [ROW_AW:0] ROW_ONE = 1;

  state_t            state;
  logic [ROW_AW:0]   num_rows, row, row_nx;
  logic [NNZ_AW:0]   cur_ptr, end_ptr;
  logic              first_ptr;
  logic              empty_row, accept, pending;
  logic              s0_vld, s0_last, s0_inj;
  logic              s1_vld, s1_last, s1_inj;
  logic              s2_vld, s2_last, s2_inj;
  logic [ROW_AW-1:0] s1_tag, s2_tag, mul_tag;
  logic [15:0]       s2_val;
  logic              mul_last;
  logic [MUL_LAT-1:0] acc_vld_sh, acc_last_sh;
  logic [ROW_AW-1:0] acc_tag_sh [MUL_LAT];

  // Unsigned compare so a decreasing row pointer also counts as an empty row.
  assign empty_row = (i_rp_data <= cur_ptr);
  assign row_nx    = row + ROW_ONE;
  assign accept    = (state == S_IDLE) && i_start && !o_done;
  assign pending   = s1_vld | s2_vld | o_mul_vld | (|acc_vld_sh);

  always_comb begin
    s0_vld  = 1'b0;
    s0_last = 1'b0;
    s0_inj  = 1'b0;
    if (state == S_WT_PTR && empty_row) begin
      s0_vld  = 1'b1;
      s0_last = 1'b1;
      s0_inj  = 1'b1;
    end else if (o_nz_rd) begin
      s0_vld  = 1'b1;
      s0_last = (cur_ptr == end_ptr - PTR_ONE);
    end
  end

  assign o_nz_addr  = cur_ptr[NNZ_AW-1:0];
  assign o_vec_addr = (s1_vld && !s1_inj) ? i_nz_col : '0;
  assign o_acc_vld  = acc_vld_sh[MUL_LAT-1];
  assign o_acc_last = acc_last_sh[MUL_LAT-1];
  assign o_acc_row  = acc_tag_sh[MUL_LAT-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      num_rows  <= '0;
      row       <= '0;
      cur_ptr   <= '0;
      end_ptr   <= '0;
      first_ptr <= 1'b0;
      o_rp_addr <= '0;
      o_nz_rd   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          num_rows  <= i_num_rows;
          row       <= '0;
          o_busy    <= 1'b1;
          o_rp_addr <= '0;
          state     <= (i_num_rows == '0) ? S_DONE : S_INIT;
        end
        S_INIT: begin
          first_ptr <= 1'b1;
          o_rp_addr <= row_nx;
          state     <= S_LD_PTR;
        end
        S_LD_PTR: begin
          // Only the first row needs rowptr[0]; later rows inherit the previous end pointer.
          if (first_ptr) cur_ptr <= i_rp_data;
          first_ptr <= 1'b0;
          state     <= S_WT_PTR;
        end
        S_WT_PTR: begin
          end_ptr <= i_rp_data;
          if (!empty_row) begin
            o_nz_rd <= 1'b1;
            state   <= S_STREAM;
          end else begin
            cur_ptr <= i_rp_data;
            row     <= row_nx;
            if (row_nx == num_rows) state <= S_DRAIN;
            else begin
              o_rp_addr <= row_nx + ROW_ONE;
              state     <= S_LD_PTR;
            end
          end
        end
        S_STREAM: begin
          cur_ptr <= cur_ptr + PTR_ONE;
          if (s0_last) begin
            o_nz_rd <= 1'b0;
            row     <= row_nx;
            if (row_nx == num_rows) state <= S_DRAIN;
            else begin
              o_rp_addr <= row_nx + ROW_ONE;
              state     <= S_LD_PTR;
            end
          end
        end
        S_DRAIN: if (!pending) state <= S_DONE;
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      {s1_vld, s1_last, s1_inj, s1_tag} <= '0;
      {s2_vld, s2_last, s2_inj, s2_tag, s2_val} <= '0;
      {o_mul_vld, o_mul_a, o_mul_b, mul_last, mul_tag} <= '0;
      acc_vld_sh  <= '0;
      acc_last_sh <= '0;
      for (int k = 0; k < MUL_LAT; k++) acc_tag_sh[k] <= '0;
    end else begin
      s1_vld  <= s0_vld;
      s1_last <= s0_last;
      s1_inj  <= s0_inj;
      s1_tag  <= row[ROW_AW-1:0];
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_inj  <= s1_inj;
      s2_tag  <= s1_tag;
      s2_val  <= (s1_vld && !s1_inj) ? i_nz_val : 16'h0000;
      o_mul_vld <= s2_vld;
      o_mul_a   <= (s2_vld && !s2_inj) ? i_vec : 16'h0000;
      o_mul_b   <= s2_val;
      mul_last  <= s2_last;
      mul_tag   <= s2_tag;
      // Tag delay line matching the external multiplier latency.
      acc_vld_sh[0]  <= o_mul_vld;
      acc_last_sh[0] <= mul_last;
      acc_tag_sh[0]  <= mul_tag;
      for (int k = 1; k < MUL_LAT; k++) begin
        acc_vld_sh[k]  <= acc_vld_sh[k-1];
        acc_last_sh[k] <= acc_last_sh[k-1];
        acc_tag_sh[k]  <= acc_tag_sh[k-1];
      end
    end
  end

`ifdef SPMV_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_perf_cycles <= '0;
      o_perf_nnz    <= '0;
    end else if (accept) begin
      o_perf_cycles <= '0;
      o_perf_nnz    <= '0;
    end else begin
      if (o_busy)  o_perf_cycles <= o_perf_cycles + 32'd1;
      if (o_nz_rd) o_perf_nnz    <= o_perf_nnz + PTR_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_spmv_csr_sched.sv
// Scoreboard bench for spmv_csr_sched: memory models, expected beats queued from the CSR contents at start.
module tb_spmv_csr_sched;
  localparam int ROW_AW = 4, NNZ_AW = 8, COL_AW = 6, MUL_LAT = 2;

  logic clk = 1'b0, rstn = 1'b0, i_start = 1'b0;
  logic [ROW_AW:0]   i_num_rows = '0;
  logic [ROW_AW:0]   o_rp_addr;
  logic [NNZ_AW:0]   rp_q = '0;
  logic [NNZ_AW-1:0] o_nz_addr;
  logic              o_nz_rd;
  logic [15:0]       val_q = '0, vec_q = '0;
  logic [COL_AW-1:0] col_q = '0, o_vec_addr;
  logic              o_mul_vld, o_acc_vld, o_acc_last, o_busy, o_done;
  logic [15:0]       o_mul_a, o_mul_b;
  logic [ROW_AW-1:0] o_acc_row;
`ifdef SPMV_SCHED_PERF_EN
  logic [31:0]       o_perf_cycles;
  logic [NNZ_AW:0]   o_perf_nnz;
`endif

  spmv_csr_sched #(.ROW_AW(ROW_AW), .NNZ_AW(NNZ_AW), .COL_AW(COL_AW), .MUL_LAT(MUL_LAT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(i_start), .i_num_rows(i_num_rows),
    .o_rp_addr(o_rp_addr), .i_rp_data(rp_q), .o_nz_addr(o_nz_addr), .o_nz_rd(o_nz_rd),
    .i_nz_val(val_q), .i_nz_col(col_q), .o_vec_addr(o_vec_addr), .i_vec(vec_q),
    .o_mul_vld(o_mul_vld), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .o_acc_vld(o_acc_vld), .o_acc_last(o_acc_last), .o_acc_row(o_acc_row),
    .o_busy(o_busy), .o_done(o_done)
`ifdef SPMV_SCHED_PERF_EN
    , .o_perf_cycles(o_perf_cycles), .o_perf_nnz(o_perf_nnz)
`endif
  );

  always #5 clk = ~clk;

  logic [NNZ_AW:0]   rp_mem  [32];
  logic [15:0]       val_mem [256];
  logic [COL_AW-1:0] col_mem [256];
  logic [15:0]       vec_mem [64];

  always @(posedge clk) begin
    rp_q  <= rp_mem[o_rp_addr];
    vec_q <= vec_mem[o_vec_addr];
    if (o_nz_rd) begin
      val_q <= val_mem[o_nz_addr];
      col_q <= col_mem[o_nz_addr];
    end
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic [3:0]  row;
  } beat_t;

  beat_t mul_q[$], acc_q[$];
  int    mul_t[$];
  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, busy_cyc = 0, done_cnt = 0, exp_nnz = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (rstn) begin
      if (o_busy) busy_cyc++;
      if (o_done) done_cnt++;
      if (o_acc_vld) begin
        if (acc_q.size() == 0) chk("acc_unexpected", 1, 0);
        else begin
          e = acc_q.pop_front();
          chk("acc_last", {31'd0, o_acc_last}, {31'd0, e.last});
          chk("acc_row", {28'd0, o_acc_row}, {28'd0, e.row});
          if (mul_t.size() == 0) chk("acc_no_mul", 1, 0);
          else chk("acc_lat", cyc - mul_t.pop_front(), MUL_LAT);
        end
      end
      if (o_mul_vld) begin
        if (mul_q.size() == 0) chk("mul_unexpected", 1, 0);
        else begin
          e = mul_q.pop_front();
          chk("mul_a", {16'd0, o_mul_a}, {16'd0, e.a});
          chk("mul_b", {16'd0, o_mul_b}, {16'd0, e.b});
          mul_t.push_back(cyc);
        end
      end
    end
  end

  task automatic build_exp(input int nrows);
    int    cur, e;
    beat_t b;
    cur = int'(rp_mem[0]);
    exp_nnz = 0;
    for (int r = 0; r < nrows; r++) begin
      e = int'(rp_mem[r+1]);
      if (e <= cur) begin
        b = '{a: 16'h0, b: 16'h0, last: 1'b1, row: 4'(r)};
        mul_q.push_back(b);
        acc_q.push_back(b);
      end else begin
        for (int k = cur; k < e; k++) begin
          b = '{a: vec_mem[col_mem[k]], b: val_mem[k], last: (k == e - 1), row: 4'(r)};
          mul_q.push_back(b);
          acc_q.push_back(b);
        end
        exp_nnz += e - cur;
      end
      cur = e;
    end
  endtask

  task automatic pulse_start(input int nrows);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_num_rows = 5'(nrows);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run(input int nrows, input bit extra_start);
    bit got = 0;
    build_exp(nrows);
    busy_cyc = 0;
    done_cnt = 0;
    pulse_start(nrows);
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #1 chk("busy_at_2nd_start", {31'd0, o_busy}, 1);
      pulse_start(1);
    end
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (o_done) got = 1;
    end
    chk("done_seen", {31'd0, got}, 1);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("mul_q_empty", mul_q.size(), 0);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("busy_clear", {31'd0, o_busy}, 0);
`ifdef SPMV_SCHED_PERF_EN
    chk("perf_nnz", {23'd0, o_perf_nnz}, exp_nnz);
    chk("perf_cycles", o_perf_cycles, busy_cyc);
`endif
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 0);
    chk({tag, "_done"}, {31'd0, o_done}, 0);
    chk({tag, "_nz_rd"}, {31'd0, o_nz_rd}, 0);
    chk({tag, "_mul_vld"}, {31'd0, o_mul_vld}, 0);
    chk({tag, "_acc_vld"}, {31'd0, o_acc_vld}, 0);
    chk({tag, "_addrs"}, {o_rp_addr, o_nz_addr, o_vec_addr}, 0);
    chk({tag, "_ops"}, {o_mul_a, o_mul_b}, 0);
    chk({tag, "_tag"}, {31'd0, o_acc_last} | {28'd0, o_acc_row}, 0);
  endtask

  task automatic set_rp(input int n, input int p0, input int p1, input int p2, input int p3, input int p4);
    int p[5];
    p = '{p0, p1, p2, p3, p4};
    for (int i = 0; i < 5 && i < n; i++) rp_mem[i] = 9'(p[i]);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 32; i++) rp_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      val_mem[i] = 16'h3C00 + 16'(i * 3);
      col_mem[i] = 6'((i * 7 + 1) % 64);
    end
    for (int i = 0; i < 64; i++) vec_mem[i] = 16'h4000 + 16'(i * 5);

    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    @(negedge clk) rstn = 1'b1;

    // Single nonzero row
    set_rp(2, 0, 1, 0, 0, 0);
    val_mem[0] = 16'h4000;
    col_mem[0] = 6'd5;
    vec_mem[5] = 16'h4C00;
    run(1, 0);

    // Empty row in the middle
    set_rp(4, 0, 3, 3, 5, 0);
    run(3, 0);

    // Zero rows, plus a start coinciding with o_done
    busy_cyc = 0;
    done_cnt = 0;
    pulse_start(0);
    chk("nr0_done_early", {31'd0, o_done}, 0);
    chk("nr0_busy", {31'd0, o_busy}, 1);
    @(posedge clk); #1;
    chk("nr0_done", {31'd0, o_done}, 1);
    i_start = 1'b1;
    i_num_rows = 5'd1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("nr0_done_pulse", {31'd0, o_done}, 0);
    chk("start_on_done_ignored", {31'd0, o_busy}, 0);
    repeat (8) @(posedge clk);
    #1 chk("nr0_single_done", done_cnt, 1);

    // Second start while busy
    set_rp(4, 0, 3, 3, 5, 0);
    run(3, 1);

    // Reset in the middle of streaming
    set_rp(2, 0, 6, 0, 0, 0);
    build_exp(1);
    pulse_start(1);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (o_nz_rd) seen = 1;
    end
    chk("stream_reached", {31'd0, seen}, 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_quiet("midrun_rst");
    mul_q.delete();
    acc_q.delete();
    mul_t.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    done_cnt = 0;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", done_cnt, 0);
    run(1, 0);

    // Four nonzeros in one row
    set_rp(2, 0, 4, 0, 0, 0);
    run(1, 0);

    // Decreasing pointer and trailing empty row
    set_rp(5, 0, 2, 1, 3, 3);
    run(4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
